// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the program loader frame decoder.
//   state_t      : decoder FSM states
//   error_code_t : reason reported on error_code for the last rejected frame
//   SYNC_BYTE    : byte value that opens a frame when seen while idle
// ---------------------------------------------------------------------------
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR_HI,
        ADDR_LO,
        LEN,
        DATA,
        CSUM
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } error_code_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/loader_timeout.sv
// ---------------------------------------------------------------------------
// loader_timeout
// Inter-byte stall counter for the loader. Used only when the top level is
// built with LOADER_TIMEOUT_EN defined.
// Ports:
//   clock   in  system clock
//   reset   in  asynchronous, active-high reset
//   clear   in  restart the count from zero (byte received, or decoder idle)
//   enable  in  count this cycle when not cleared
//   expired out count has reached TIMEOUT_CYCLES-1
// ---------------------------------------------------------------------------
module loader_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CountWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CountWidth-1:0] LastCount = CountWidth'(TIMEOUT_CYCLES - 1);

    logic [CountWidth-1:0] count_q;

    assign expired = (count_q == LastCount);

    // The count holds at its terminal value so expired stays asserted until
    // the decoder reacts and clears it by returning to idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/program_loader_frame.sv
// ---------------------------------------------------------------------------
// program_loader_frame
// Decodes loader frames from the UART receiver byte stream:
//   0xA5, ADDR_HI, ADDR_LO, LEN, LEN data bytes, CSUM
// Data bytes become program memory write strobes; a LEN=0 frame is a run
// command for ADDR. The checksum covers ADDR_HI..last data byte plus CSUM
// and must sum to zero mod 256.
// Optional build macro: LOADER_TIMEOUT_EN enables an inter-byte timeout
// that aborts a stalled frame after TIMEOUT_CYCLES clocks.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   rx_data, rx_valid   received byte and its one-cycle valid strobe
//   mem_we/addr/wdata   registered one-cycle memory write
//   run_pulse, run_addr execute request and its held address
//   frame_done          one-cycle pulse, checksum good
//   frame_error         one-cycle pulse, frame rejected
//   error_code          0 none, 1 checksum, 2 timeout; held until next SYNC
//   busy                high whenever a frame is in progress
// ---------------------------------------------------------------------------
module program_loader_frame
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  run_pulse,
    output logic [ADDR_WIDTH-1:0] run_addr,
    output logic                  frame_done,
    output logic                  frame_error,
    output logic [1:0]            error_code,
    output logic                  busy
);

    state_t                state_q;
    error_code_t           error_q;
    logic [7:0]            sum_q;
    logic [7:0]            sum_next;
    logic [7:0]            addr_hi_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            cnt_q;
    logic                  len_zero_q;

    assign sum_next   = sum_q + rx_data;
    assign busy       = (state_q != IDLE);
    assign error_code = error_q;

`ifdef LOADER_TIMEOUT_EN
    logic timeout_expired;

    // A received byte or an idle decoder restarts the stall count.
    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (rx_valid || (state_q == IDLE)),
        .enable (1'b1),
        .expired(timeout_expired)
    );
`endif

    // Frame decoder. Pulse outputs default low each cycle so they last one
    // clock. addr_q is the running write pointer; for a LEN=0 frame it is
    // never advanced, so it still holds the frame address at CSUM time.
    // A byte arriving on the expiry cycle takes priority over the timeout.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            error_q     <= ERR_NONE;
            sum_q       <= '0;
            addr_hi_q   <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            len_zero_q  <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            run_pulse   <= 1'b0;
            run_addr    <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            mem_we      <= 1'b0;
            run_pulse   <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            if (rx_valid) begin
                case (state_q)
                    IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_q <= ADDR_HI;
                            sum_q   <= '0;
                            error_q <= ERR_NONE;
                        end
                    end
                    ADDR_HI: begin
                        addr_hi_q <= rx_data;
                        sum_q     <= sum_next;
                        state_q   <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr_q  <= ADDR_WIDTH'({addr_hi_q, rx_data});
                        sum_q   <= sum_next;
                        state_q <= LEN;
                    end
                    LEN: begin
                        cnt_q      <= rx_data;
                        sum_q      <= sum_next;
                        len_zero_q <= (rx_data == 8'd0);
                        state_q    <= (rx_data == 8'd0) ? CSUM : DATA;
                    end
                    DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr_q;
                        mem_wdata <= rx_data;
                        addr_q    <= addr_q + 1'b1;
                        sum_q     <= sum_next;
                        cnt_q     <= cnt_q - 8'd1;
                        if (cnt_q == 8'd1) begin
                            state_q <= CSUM;
                        end
                    end
                    CSUM: begin
                        if (sum_next == 8'd0) begin
                            frame_done <= 1'b1;
                            if (len_zero_q) begin
                                run_pulse <= 1'b1;
                                run_addr  <= addr_q;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            error_q     <= ERR_CSUM;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
`ifdef LOADER_TIMEOUT_EN
            end else if (timeout_expired && (state_q != IDLE)) begin
                frame_error <= 1'b1;
                error_q     <= ERR_TIMEOUT;
                state_q     <= IDLE;
`endif
            end
        end
    end

endmodule
